// File: rtl/axil_sdram_pkg.sv
// rtl/axil_sdram_pkg.sv - shared types and default widths for the AXI-Lite to SDRAM command scheduler
package axil_sdram_pkg;

  localparam int DEF_ADDR_WIDTH    = 32;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_MAX_RD_STREAK = 4;
  localparam int STREAK_W          = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP     = 3'd1,
    LATCH   = 3'd2,
    ISSUE   = 3'd3,
    RD_WAIT = 3'd4
  } sched_state_t;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_t;

endpackage

// File: rtl/axil_sdram_rr_arb.sv
// rtl/axil_sdram_rr_arb.sv - combinational write/read arbiter; SCHED_RD_PRIORITY_EN selects read-priority with streak limit
module axil_sdram_rr_arb
  import axil_sdram_pkg::*;
(
  input  logic i_wr_elig,
  input  logic i_rd_elig,
  input  logic i_last_grant,
`ifdef SCHED_RD_PRIORITY_EN
  input  logic i_streak_max,
`endif
  output logic o_grant_valid,
  output logic o_grant
);

  logic w_tie_grant;

`ifdef SCHED_RD_PRIORITY_EN
  // Reads win ties until the streak limit hands one tie to the write side.
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
  assign w_tie_grant = i_streak_max ? GNT_WR : GNT_RD;
`else
  assign w_tie_grant = (i_last_grant == GNT_RD) ? GNT_WR : GNT_RD;
`endif

  assign o_grant_valid = i_wr_elig | i_rd_elig;

  always_comb begin
    o_grant = GNT_WR;
    if (i_wr_elig && i_rd_elig) o_grant = w_tie_grant;
    else if (i_rd_elig)         o_grant = GNT_RD;
  end

endmodule

// File: rtl/axil_sdram_cmd_sched.sv
// rtl/axil_sdram_cmd_sched.sv - pops AXI-Lite command FIFOs and issues one SDRAM command at a time; option SCHED_RD_PRIORITY_EN
module axil_sdram_cmd_sched
  import axil_sdram_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int MAX_RD_STREAK = DEF_MAX_RD_STREAK
) (
  input  logic                  s_axil_clk,
  input  logic                  s_axil_resetn,
  input  logic [ADDR_WIDTH-1:0] waddr_fifo_dout,
  input  logic                  waddr_fifo_empty,
  output logic                  waddr_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] wdata_fifo_dout,
  input  logic                  wdata_fifo_empty,
  output logic                  wdata_fifo_rd_en,
  input  logic [ADDR_WIDTH-1:0] raddr_fifo_dout,
  input  logic                  raddr_fifo_empty,
  output logic                  raddr_fifo_rd_en,
  output logic [DATA_WIDTH-1:0] rdata_fifo_din,
  output logic                  rdata_fifo_wr_en,
  input  logic                  rdata_fifo_full,
  output logic                  sdram_req,
  output logic                  sdram_wr,
  output logic [ADDR_WIDTH-1:0] sdram_addr,
  output logic [DATA_WIDTH-1:0] sdram_wdata,
  input  logic                  sdram_ack,
  input  logic                  sdram_rd_valid,
  input  logic [DATA_WIDTH-1:0] sdram_rdata,
  output logic                  sched_busy
);

  sched_state_t          r_state, w_state_nxt;
  grant_t                r_last_grant, w_grant;
  logic                  w_wr_elig, w_rd_elig, w_grant_valid, w_grant_bit;
  logic                  w_waddr_rd_en, w_wdata_rd_en, w_raddr_rd_en;
  logic                  w_req, w_wr, w_rdata_wr_en, w_grant_now;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata, w_rdata_din;

  // Read eligibility reserves a result slot up front so RD_WAIT never stalls on a full FIFO.
  assign w_wr_elig   = !waddr_fifo_empty && !wdata_fifo_empty;
  assign w_rd_elig   = !raddr_fifo_empty && !rdata_fifo_full;
  assign w_grant     = grant_t'(w_grant_bit);
  assign w_grant_now = (r_state == IDLE) && w_grant_valid;

`ifdef SCHED_RD_PRIORITY_EN
  logic [STREAK_W-1:0] r_streak;
  logic                w_streak_max;
  assign w_streak_max = (r_streak >= STREAK_W'(MAX_RD_STREAK));

  always_ff @(posedge s_axil_clk or negedge s_axil_resetn) begin
    if (!s_axil_resetn)           r_streak <= '0;
    else if (w_grant_now) begin
      if (w_grant == GNT_WR)      r_streak <= '0;
      else if (w_wr_elig)         r_streak <= r_streak + 1'b1;
      else                        r_streak <= '0;
    end
  end
`else
  logic [STREAK_W-1:0] w_unused_streak_cfg;
  assign w_unused_streak_cfg = STREAK_W'(MAX_RD_STREAK);
`endif

  axil_sdram_rr_arb u_arb (
    .i_wr_elig     (w_wr_elig),
    .i_rd_elig     (w_rd_elig),
    .i_last_grant  (r_last_grant),
`ifdef SCHED_RD_PRIORITY_EN
    .i_streak_max  (w_streak_max),
`endif
    .o_grant_valid (w_grant_valid),
    .o_grant       (w_grant_bit)
  );

  always_ff @(posedge s_axil_clk or negedge s_axil_resetn) begin
    if (!s_axil_resetn) begin
      r_state          <= IDLE;
      r_last_grant     <= GNT_RD;
      waddr_fifo_rd_en <= 1'b0;
      wdata_fifo_rd_en <= 1'b0;
      raddr_fifo_rd_en <= 1'b0;
      rdata_fifo_din   <= '0;
      rdata_fifo_wr_en <= 1'b0;
      sdram_req        <= 1'b0;
      sdram_wr         <= 1'b0;
      sdram_addr       <= '0;
      sdram_wdata      <= '0;
      sched_busy       <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      if (w_grant_now) r_last_grant <= w_grant;
      waddr_fifo_rd_en <= w_waddr_rd_en;
      wdata_fifo_rd_en <= w_wdata_rd_en;
      raddr_fifo_rd_en <= w_raddr_rd_en;
      rdata_fifo_din   <= w_rdata_din;
      rdata_fifo_wr_en <= w_rdata_wr_en;
      sdram_req        <= w_req;
      sdram_wr         <= w_wr;
      sdram_addr       <= w_addr;
      sdram_wdata      <= w_wdata;
      sched_busy       <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_state_nxt = POP;
      POP:     w_state_nxt = LATCH;
      LATCH:   w_state_nxt = ISSUE;
      ISSUE:   if (sdram_ack)
                 w_state_nxt = (r_last_grant == GNT_RD && !sdram_rd_valid) ? RD_WAIT : IDLE;
      RD_WAIT: if (sdram_rd_valid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_last_grant doubles as the direction of the transaction in flight.
  always_comb begin
    w_waddr_rd_en = 1'b0;
    w_wdata_rd_en = 1'b0;
    w_raddr_rd_en = 1'b0;
    w_rdata_din   = rdata_fifo_din;
    w_rdata_wr_en = 1'b0;
    w_req         = sdram_req;
    w_wr          = sdram_wr;
    w_addr        = sdram_addr;
    w_wdata       = sdram_wdata;
    case (r_state)
      IDLE: if (w_grant_valid) begin
        if (w_grant == GNT_WR) begin
          w_waddr_rd_en = 1'b1;
          w_wdata_rd_en = 1'b1;
        end else begin
          w_raddr_rd_en = 1'b1;
        end
      end
      LATCH: begin
        w_req = 1'b1;
        w_wr  = (r_last_grant == GNT_WR);
        if (r_last_grant == GNT_WR) begin
          w_addr  = waddr_fifo_dout;
          w_wdata = wdata_fifo_dout;
        end else begin
          w_addr  = raddr_fifo_dout;
        end
      end
      ISSUE: if (sdram_ack) begin
        w_req = 1'b0;
        if (r_last_grant == GNT_RD && sdram_rd_valid) begin
          w_rdata_din   = sdram_rdata;
          w_rdata_wr_en = 1'b1;
        end
      end
      RD_WAIT: if (sdram_rd_valid) begin
        w_rdata_din   = sdram_rdata;
        w_rdata_wr_en = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
